// File: rtl/vga_pkg.sv
// Shared types, default 640x480 timing and colour helpers for the VGA tile painter.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    localparam int VGA_640X480_CLK_DIV  = 2;
    localparam int VGA_640X480_H_ACTIVE = 640;
    localparam int VGA_640X480_H_FP     = 16;
    localparam int VGA_640X480_H_SYNC   = 96;
    localparam int VGA_640X480_H_BP     = 48;
    localparam int VGA_640X480_V_ACTIVE = 480;
    localparam int VGA_640X480_V_FP     = 10;
    localparam int VGA_640X480_V_SYNC   = 2;
    localparam int VGA_640X480_V_BP     = 33;

    localparam rgb8_t RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb8_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One bit per channel {r,g,b} expanded to full-scale 8-bit channels.
    function automatic rgb8_t expand3(input logic [2:0] c);
        rgb8_t o;
        o.r = c[2] ? 8'hFF : 8'h00;
        o.g = c[1] ? 8'hFF : 8'h00;
        o.b = c[0] ? 8'hFF : 8'h00;
        return o;
    endfunction

endpackage

// File: rtl/vga_tile_painter_if.sv
// VGA pin bundle between the tile painter and the DAC / connector.
interface vga_tile_painter_if;
    logic       hsync;
    logic       vsync;
    logic       n_sync;
    logic       n_blanc;
    logic       pix_ce;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (output hsync, vsync, n_sync, n_blanc, pix_ce, r, g, b);
    modport slave  (input  hsync, vsync, n_sync, n_blanc, pix_ce, r, g, b);
endinterface

// File: rtl/vga_timing.sv
// Pixel divider, raster counters, raw syncs and divider-free tile coordinates.
module vga_timing
    import vga_pkg::*;
#(
    parameter  int CLK_DIV   = VGA_640X480_CLK_DIV,
    parameter  int H_ACTIVE  = VGA_640X480_H_ACTIVE,
    parameter  int H_FP      = VGA_640X480_H_FP,
    parameter  int H_SYNC    = VGA_640X480_H_SYNC,
    parameter  int H_BP      = VGA_640X480_H_BP,
    parameter  int V_ACTIVE  = VGA_640X480_V_ACTIVE,
    parameter  int V_FP      = VGA_640X480_V_FP,
    parameter  int V_SYNC    = VGA_640X480_V_SYNC,
    parameter  int V_BP      = VGA_640X480_V_BP,
    parameter  int GRID_COLS = 4,
    parameter  int GRID_ROWS = 4,
    localparam int TILE_W    = H_ACTIVE / GRID_COLS,
    localparam int TILE_H    = V_ACTIVE / GRID_ROWS,
    localparam int TXW       = clog2_min1(TILE_W),
    localparam int TYW       = clog2_min1(TILE_H),
    localparam int COLW      = clog2_min1(GRID_COLS),
    localparam int ROWW      = clog2_min1(GRID_ROWS)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            pix_ce,
    output logic            hsync_raw,
    output logic            vsync_raw,
    output logic            active,
    output logic [COLW-1:0] tile_col,
    output logic [ROWW-1:0] tile_row,
    output logic [TXW-1:0]  tx_sub,
    output logic [TYW-1:0]  ty_sub
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = clog2_min1(H_TOTAL);
    localparam int VW      = clog2_min1(V_TOTAL);
    localparam int DW      = clog2_min1(CLK_DIV);

    logic [DW-1:0]   div_q, div_d;
    logic            pix_ce_q, pix_ce_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic [TXW-1:0]  tx_sub_q, tx_sub_d;
    logic [TYW-1:0]  ty_sub_q, ty_sub_d;
    logic [COLW-1:0] tile_col_q, tile_col_d;
    logic [ROWW-1:0] tile_row_q, tile_row_d;
    logic            h_last_s, v_last_s, tx_last_s, ty_last_s;

    // Next-state for the divider, raster counters and tile sub-counters.
    always_comb begin
        h_last_s   = (hcnt_q == HW'(H_TOTAL - 1));
        v_last_s   = (vcnt_q == VW'(V_TOTAL - 1));
        tx_last_s  = (tx_sub_q == TXW'(TILE_W - 1));
        ty_last_s  = (ty_sub_q == TYW'(TILE_H - 1));
        div_d      = div_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        tx_sub_d   = tx_sub_q;
        ty_sub_d   = ty_sub_q;
        tile_col_d = tile_col_q;
        tile_row_d = tile_row_q;

        if (div_q == DW'(CLK_DIV - 1)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
        // Registered strobe: high exactly while the divider sits at its last count.
        pix_ce_d = (div_d == DW'(CLK_DIV - 1));

        if (pix_ce_q) begin
            if (h_last_s) begin
                hcnt_d     = '0;
                tx_sub_d   = '0;
                tile_col_d = '0;
                if (v_last_s) begin
                    vcnt_d     = '0;
                    ty_sub_d   = '0;
                    tile_row_d = '0;
                end else if (ty_last_s) begin
                    vcnt_d   = vcnt_q + VW'(1);
                    ty_sub_d = '0;
                    if (tile_row_q != ROWW'(GRID_ROWS - 1)) begin
                        tile_row_d = tile_row_q + ROWW'(1);
                    end else begin
                        tile_row_d = tile_row_q;
                    end
                end else begin
                    vcnt_d   = vcnt_q + VW'(1);
                    ty_sub_d = ty_sub_q + TYW'(1);
                end
            end else if (tx_last_s) begin
                hcnt_d   = hcnt_q + HW'(1);
                tx_sub_d = '0;
                // Saturate so blanking pixels never index past the last tile.
                if (tile_col_q != COLW'(GRID_COLS - 1)) begin
                    tile_col_d = tile_col_q + COLW'(1);
                end else begin
                    tile_col_d = tile_col_q;
                end
            end else begin
                hcnt_d   = hcnt_q + HW'(1);
                tx_sub_d = tx_sub_q + TXW'(1);
            end
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // Timing state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            pix_ce_q   <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            tx_sub_q   <= '0;
            ty_sub_q   <= '0;
            tile_col_q <= '0;
            tile_row_q <= '0;
        end else begin
            div_q      <= div_d;
            pix_ce_q   <= pix_ce_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            tx_sub_q   <= tx_sub_d;
            ty_sub_q   <= ty_sub_d;
            tile_col_q <= tile_col_d;
            tile_row_q <= tile_row_d;
        end
    end

    // Raw syncs and active flag decoded from the current raster position.
    always_comb begin
        if ((hcnt_q >= HW'(H_ACTIVE + H_FP)) && (hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC))) begin
            hsync_raw = 1'b0;
        end else begin
            hsync_raw = 1'b1;
        end
        if ((vcnt_q >= VW'(V_ACTIVE + V_FP)) && (vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC))) begin
            vsync_raw = 1'b0;
        end else begin
            vsync_raw = 1'b1;
        end
        active = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
    end

    assign pix_ce   = pix_ce_q;
    assign tile_col = tile_col_q;
    assign tile_row = tile_row_q;
    assign tx_sub   = tx_sub_q;
    assign ty_sub   = ty_sub_q;

endmodule

// File: rtl/vga_tile_painter.sv
// Tile painter top: button synchronisers, cursor, per-tile colour store, colour mux
// and the single pixel-aligned output stage shared by rgb and syncs.
module vga_tile_painter
    import vga_pkg::*;
#(
    parameter  int CLK_DIV   = VGA_640X480_CLK_DIV,
    parameter  int H_ACTIVE  = VGA_640X480_H_ACTIVE,
    parameter  int H_FP      = VGA_640X480_H_FP,
    parameter  int H_SYNC    = VGA_640X480_H_SYNC,
    parameter  int H_BP      = VGA_640X480_H_BP,
    parameter  int V_ACTIVE  = VGA_640X480_V_ACTIVE,
    parameter  int V_FP      = VGA_640X480_V_FP,
    parameter  int V_SYNC    = VGA_640X480_V_SYNC,
    parameter  int V_BP      = VGA_640X480_V_BP,
    parameter  int GRID_COLS = 4,
    parameter  int GRID_ROWS = 4,
    parameter  int BORDER    = 2,
    localparam int N_TILES   = GRID_COLS * GRID_ROWS,
    localparam int CURW      = clog2_min1(N_TILES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               next_btn,
    input  logic               paint_btn,
    input  logic               clear_btn,
    input  logic [2:0]         sw,
    vga_tile_painter_if.master vga,
    output logic [CURW-1:0]    cursor
);

    localparam int TILE_W = H_ACTIVE / GRID_COLS;
    localparam int TILE_H = V_ACTIVE / GRID_ROWS;
    localparam int TXW    = clog2_min1(TILE_W);
    localparam int TYW    = clog2_min1(TILE_H);
    localparam int COLW   = clog2_min1(GRID_COLS);
    localparam int ROWW   = clog2_min1(GRID_ROWS);

    logic            pix_ce_s, hsync_raw_s, vsync_raw_s, active_s;
    logic [COLW-1:0] tile_col_s;
    logic [ROWW-1:0] tile_row_s;
    logic [TXW-1:0]  tx_sub_s;
    logic [TYW-1:0]  ty_sub_s;

    // Button vectors are ordered {clear, paint, next}.
    logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [2:0]      act_s;
    logic [CURW-1:0] cursor_q, cursor_d;
    logic [2:0]      tiles_q [N_TILES];
    logic [2:0]      tiles_d [N_TILES];
    logic [CURW-1:0] tile_idx_s;
    logic            in_cursor_s, on_edge_s;
    rgb8_t           pix_s, rgb_q, rgb_d;
    logic            hsync_q, hsync_d, vsync_q, vsync_d;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .GRID_COLS(GRID_COLS),
        .GRID_ROWS(GRID_ROWS)
    ) u_timing (
        .clk      (clk),
        .rst_n    (reset),
        .pix_ce   (pix_ce_s),
        .hsync_raw(hsync_raw_s),
        .vsync_raw(vsync_raw_s),
        .active   (active_s),
        .tile_col (tile_col_s),
        .tile_row (tile_row_s),
        .tx_sub   (tx_sub_s),
        .ty_sub   (ty_sub_s)
    );

    // Two-flop synchronisers followed by a rising-edge detector per button.
    always_comb begin
        sync1_d = {clear_btn, paint_btn, next_btn};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        act_s   = sync2_q & ~prev_q;
    end

    // Tile store and cursor updates; clear overrides paint, next is independent.
    always_comb begin
        tiles_d  = tiles_q;
        cursor_d = cursor_q;
        if (act_s[2]) begin
            for (int i = 0; i < N_TILES; i++) begin
                tiles_d[i] = 3'b000;
            end
        end else if (act_s[1]) begin
            // Uses the pre-advance cursor, so paint+next writes the old tile.
            tiles_d[cursor_q] = sw;
        end else begin
            tiles_d = tiles_q;
        end
        if (act_s[0]) begin
            if (cursor_q == CURW'(N_TILES - 1)) begin
                cursor_d = '0;
            end else begin
                cursor_d = cursor_q + CURW'(1);
            end
        end else begin
            cursor_d = cursor_q;
        end
    end

    // Colour of the pixel at the current raster position.
    always_comb begin
        tile_idx_s  = CURW'(tile_row_s) * CURW'(GRID_COLS) + CURW'(tile_col_s);
        in_cursor_s = (tile_idx_s == cursor_q);
        on_edge_s   = (32'(tx_sub_s) < BORDER) || (32'(tx_sub_s) >= (TILE_W - BORDER)) ||
                      (32'(ty_sub_s) < BORDER) || (32'(ty_sub_s) >= (TILE_H - BORDER));
        pix_s       = RGB_BLACK;
        if (!active_s) begin
            pix_s = RGB_BLACK;
        end else if (in_cursor_s && on_edge_s) begin
            pix_s = RGB_WHITE;
        end else begin
            pix_s = expand3(tiles_q[tile_idx_s]);
        end
    end

    // One pixel-wide stage keeps rgb and both syncs mutually aligned.
    always_comb begin
        if (pix_ce_s) begin
            rgb_d   = pix_s;
            hsync_d = hsync_raw_s;
            vsync_d = vsync_raw_s;
        end else begin
            rgb_d   = rgb_q;
            hsync_d = hsync_q;
            vsync_d = vsync_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            prev_q   <= 3'b000;
            cursor_q <= '0;
            for (int i = 0; i < N_TILES; i++) begin
                tiles_q[i] <= 3'b000;
            end
            rgb_q    <= RGB_BLACK;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            cursor_q <= cursor_d;
            for (int i = 0; i < N_TILES; i++) begin
                tiles_q[i] <= tiles_d[i];
            end
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign vga.hsync   = hsync_q;
    assign vga.vsync   = vsync_q;
    assign vga.n_sync  = 1'b0;
    assign vga.n_blanc = 1'b1;
    assign vga.pix_ce  = pix_ce_s;
    assign vga.r       = rgb_q.r;
    assign vga.g       = rgb_q.g;
    assign vga.b       = rgb_q.b;
    assign cursor      = cursor_q;

endmodule

// File: tb/tb_vga_tile_painter.sv
// Directed bench: a shrunken-raster painter (A) and a CLK_DIV=1, 8x2 painter with 640x480 H timing (B).
module tb_vga_tile_painter;

    localparam int A_HT = 80;     // 64 + 4 + 8 + 4
    localparam int A_F  = 3200;   // 80 x 40 lines
    localparam int B_HT = 800;
    localparam int B_F  = 8800;   // 800 x 11 lines

    logic       clk = 1'b0;
    logic       rst_a_n = 1'b0;
    logic       rst_b_n = 1'b0;
    logic       next_btn = 1'b0;
    logic       paint_btn = 1'b0;
    logic       clear_btn = 1'b0;
    logic [2:0] sw = 3'b000;
    logic [3:0] cur_a, cur_b;

    int n_vec = 0;
    int n_bad = 0;
    int pc_a = 0;
    int pc_b = 0;

    logic [23:0] cap_rgb [3200];
    logic        cap_hs  [3200];
    logic        cap_vs  [3200];

    vga_tile_painter_if va();
    vga_tile_painter_if vb();

    vga_tile_painter #(
        .CLK_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .GRID_COLS(4), .GRID_ROWS(4), .BORDER(2)
    ) dut_a (
        .clk(clk), .reset(rst_a_n), .next_btn(next_btn), .paint_btn(paint_btn),
        .clear_btn(clear_btn), .sw(sw), .vga(va), .cursor(cur_a)
    );

    vga_tile_painter #(
        .CLK_DIV(1), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .GRID_COLS(8), .GRID_ROWS(2), .BORDER(1)
    ) dut_b (
        .clk(clk), .reset(rst_b_n), .next_btn(next_btn), .paint_btn(paint_btn),
        .clear_btn(clear_btn), .sw(sw), .vga(vb), .cursor(cur_b)
    );

    always #5 clk = ~clk;

    // pix_ce pulses since reset release; at a pulse, outputs show pixel (count - 2).
    always @(negedge clk) begin
        if (!rst_a_n) pc_a <= 0;
        else if (va.pix_ce) pc_a <= pc_a + 1;
        if (!rst_b_n) pc_b <= 0;
        else if (vb.pix_ce) pc_b <= pc_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic n, input logic p, input logic c);
        @(negedge clk);
        next_btn = n; paint_btn = p; clear_btn = c;
        repeat (5) @(negedge clk);
        next_btn = 1'b0; paint_btn = 1'b0; clear_btn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Record npix consecutive displayed pixels starting at the next frame start.
    task automatic capture(input bit sel, input int frame, input int npix);
        int shown, start, got, budget, idx;
        got = 0; start = -1; budget = (frame + npix) * 4 + 100;
        while (got < npix && budget > 0) begin
            @(negedge clk); #1;
            budget--;
            if (sel ? vb.pix_ce : va.pix_ce) begin
                shown = (sel ? pc_b : pc_a) - 2;
                if (start < 0 && shown >= 0 && (shown % frame) == 0) start = shown;
                if (start >= 0) begin
                    idx = shown - start;
                    cap_rgb[idx] = sel ? {vb.r, vb.g, vb.b} : {va.r, va.g, va.b};
                    cap_hs[idx]  = sel ? vb.hsync : va.hsync;
                    cap_vs[idx]  = sel ? vb.vsync : va.vsync;
                    got++;
                end
            end
        end
        chk("capture_complete", got, npix);
    endtask

    function automatic int first_low(input bit v, input int from, input int len);
        for (int i = from; i < from + len; i++) begin
            if ((v ? cap_vs[i] : cap_hs[i]) == 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic int count_low(input bit v, input int from, input int len);
        int n;
        n = 0;
        for (int i = from; i < from + len; i++) begin
            if ((v ? cap_vs[i] : cap_hs[i]) == 1'b0) n++;
        end
        return n;
    endfunction

    initial begin
        bit seen;
        int ce_hi;

        // ---- 1: reset values, mid-line reset, timing ----
        repeat (3) @(negedge clk);
        chk("rst_hsync", va.hsync, 1);
        chk("rst_vsync", va.vsync, 1);
        chk("rst_rgb", {va.r, va.g, va.b}, 0);
        chk("rst_cursor", cur_a, 0);
        chk("n_sync", va.n_sync, 0);
        chk("n_blanc", va.n_blanc, 1);
        #1 rst_a_n = 1'b1;

        press(1'b1, 1'b0, 1'b0);
        chk("t1_cursor_1", cur_a, 1);
        sw = 3'b111;
        press(1'b0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (va.hsync == 1'b0) seen = 1'b1;
        end
        chk("t1_hs_low_before_rst", seen, 1);
        #2 rst_a_n = 1'b0;
        #1;
        chk("t1_midrst_hsync", va.hsync, 1);
        chk("t1_midrst_vsync", va.vsync, 1);
        chk("t1_midrst_rgb", {va.r, va.g, va.b}, 0);
        chk("t1_midrst_cursor", cur_a, 0);
        repeat (3) @(negedge clk);
        #1 rst_a_n = 1'b1;

        capture(1'b0, A_F, A_F);
        chk("t1_hs_start", first_low(1'b0, 0, A_HT), 68);
        chk("t1_hs_width", count_low(1'b0, 0, A_HT), 8);
        chk("t1_hs_period", first_low(1'b0, A_HT, A_HT), 148);
        chk("t1_vs_start", first_low(1'b1, 0, A_F), 2720);
        chk("t1_vs_pixels", count_low(1'b1, 0, A_F), 160);
        chk("t1_px_0_0", cap_rgb[0], 24'hFFFFFF);
        chk("t1_px_8_4", cap_rgb[4*A_HT + 8], 24'h000000);
        chk("t1_px_24_4_cleared", cap_rgb[4*A_HT + 24], 24'h000000);
        chk("t1_px_70_0_blank", cap_rgb[70], 24'h000000);

        // ---- 2: paint tile 0 ----
        sw = 3'b101;
        press(1'b0, 1'b1, 1'b0);
        capture(1'b0, A_F, A_F);
        chk("t2_px_8_4", cap_rgb[4*A_HT + 8], 24'hFF00FF);
        chk("t2_px_0_0", cap_rgb[0], 24'hFFFFFF);
        chk("t2_px_20_4", cap_rgb[4*A_HT + 20], 24'h000000);
        chk("t2_px_13_4", cap_rgb[4*A_HT + 13], 24'hFF00FF);
        chk("t2_px_14_4", cap_rgb[4*A_HT + 14], 24'hFFFFFF);
        chk("t2_px_8_1", cap_rgb[1*A_HT + 8], 24'hFFFFFF);
        chk("t2_px_8_2", cap_rgb[2*A_HT + 8], 24'hFF00FF);
        chk("t2_px_15_7", cap_rgb[7*A_HT + 15], 24'hFFFFFF);

        // ---- 3: cursor walk, paint+next together ----
        for (int i = 1; i <= 16; i++) begin
            press(1'b1, 1'b0, 1'b0);
            chk($sformatf("t3_walk_%0d", i), cur_a, i % 16);
        end
        repeat (3) press(1'b1, 1'b0, 1'b0);
        chk("t3_cursor_3", cur_a, 3);
        sw = 3'b011;
        press(1'b1, 1'b1, 1'b0);
        chk("t3_cursor_4", cur_a, 4);
        capture(1'b0, A_F, A_F);
        chk("t3_px_56_4", cap_rgb[4*A_HT + 56], 24'h00FFFF);
        chk("t3_px_8_12", cap_rgb[12*A_HT + 8], 24'h000000);
        chk("t3_px_0_8", cap_rgb[8*A_HT + 0], 24'hFFFFFF);
        chk("t3_px_0_0", cap_rgb[0], 24'hFF00FF);

        // ---- 4: clear beats paint ----
        sw = 3'b111;
        press(1'b0, 1'b1, 1'b1);
        chk("t4_cursor", cur_a, 4);
        capture(1'b0, A_F, A_F);
        chk("t4_px_8_4", cap_rgb[4*A_HT + 8], 24'h000000);
        chk("t4_px_56_4", cap_rgb[4*A_HT + 56], 24'h000000);
        chk("t4_px_8_12", cap_rgb[12*A_HT + 8], 24'h000000);
        chk("t4_px_0_0", cap_rgb[0], 24'h000000);
        chk("t4_px_40_28", cap_rgb[28*A_HT + 40], 24'h000000);
        chk("t4_px_0_8", cap_rgb[8*A_HT + 0], 24'hFFFFFF);

        // ---- 5: held button, sub-cycle glitch ----
        @(negedge clk);
        next_btn = 1'b1;
        repeat (1000) @(negedge clk);
        next_btn = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_held_once", cur_a, 5);
        #1 next_btn = 1'b1;
        #2 next_btn = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_glitch_0_or_1", (cur_a == 4'd5) || (cur_a == 4'd6), 1);

        // ---- 6: CLK_DIV=1, 8x2 grid ----
        sw = 3'b010;
        @(negedge clk);
        #1 rst_b_n = 1'b1;
        repeat (2) @(negedge clk);
        ce_hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (vb.pix_ce) ce_hi++;
        end
        chk("t6_pix_ce_const", ce_hi, 50);
        press(1'b0, 1'b1, 1'b0);
        chk("t6_cursor_b", cur_b, 0);
        capture(1'b1, B_F, 2*B_HT);
        chk("t6_hs_start", first_low(1'b0, 0, B_HT), 656);
        chk("t6_hs_width", count_low(1'b0, 0, B_HT), 96);
        chk("t6_hs_period", first_low(1'b0, B_HT, B_HT), 1456);
        chk("t6_px_0_1", cap_rgb[B_HT + 0], 24'hFFFFFF);
        chk("t6_px_1_1", cap_rgb[B_HT + 1], 24'h00FF00);
        chk("t6_px_40_1", cap_rgb[B_HT + 40], 24'h00FF00);
        chk("t6_px_79_1", cap_rgb[B_HT + 79], 24'hFFFFFF);
        chk("t6_px_80_1", cap_rgb[B_HT + 80], 24'h000000);
        chk("t6_px_79_0", cap_rgb[79], 24'hFFFFFF);
        chk("t6_px_80_0", cap_rgb[80], 24'h000000);
        chk("t6_px_700_1_blank", cap_rgb[B_HT + 700], 24'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
